// File: rtl/matmul_job_scheduler_if.sv
// Requester/multiplier-side signal bundle for matmul_job_scheduler.
// master = scheduler side, slave = requesters plus multiplier side.
interface matmul_job_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    op_sel;
    logic               mm_start;
    logic               mm_done;
    logic               mm_clr;
    logic               res_load;
    logic [NUM_REQ-1:0] rsp_valid;
    logic               rsp_err;
    logic               busy;
    logic [15:0]        job_cnt;
    logic [7:0]         tmo_cnt;

    modport master (
        input  req, mm_done,
        output gnt, op_sel, mm_start, mm_clr, res_load, rsp_valid, rsp_err,
               busy, job_cnt, tmo_cnt
    );

    modport slave (
        output req, mm_done,
        input  gnt, op_sel, mm_start, mm_clr, res_load, rsp_valid, rsp_err,
               busy, job_cnt, tmo_cnt
    );
endinterface

// File: rtl/matmul_job_scheduler.sv
// Round-robin scheduler sharing one 4x4 matrix multiplier among NUM_REQ requesters.
// Optional job/timeout statistics counters: define MATMUL_SCHED_STATS_EN.
module matmul_job_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    matmul_job_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_op_sel;
    logic [ID_W-1:0]    r_last;
    logic [15:0]        r_wdog;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_load_grant;
    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_onehot;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_winner;
    logic               w_found;

    assign w_onehot = NUM_REQ'(1) << r_op_sel;

    // The winner's req is still high during RESP and must not re-win.
    always_comb begin
        w_mask   = bus.req;
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        if (r_state == S_RESP) w_mask[r_op_sel] = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_idx = ID_W'((32'(r_last) + i) % NUM_REQ);
            if (!w_found && w_mask[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_err_nxt    = r_err;
        w_load_grant = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = S_GRANT;
                    w_load_grant = 1'b1;
                end
            end
            S_GRANT:  w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.mm_done) begin
                    w_state_nxt = S_RESP;
                    w_err_nxt   = 1'b0;
                end else if (r_wdog == LP_TMO_LAST) begin
                    w_state_nxt = S_RESP;
                    w_err_nxt   = 1'b1;
                end
            end
            S_RESP: begin
                if (w_found) begin
                    w_state_nxt  = S_GRANT;
                    w_load_grant = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_op_sel <= '0;
            r_last   <= ID_W'(NUM_REQ - 1);
            r_wdog   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (w_load_grant) begin
                r_op_sel <= w_winner;
                r_last   <= w_winner;
            end
            if (r_state == S_LAUNCH) r_wdog <= '0;
            else if (r_state == S_WAIT) r_wdog <= r_wdog + 16'd1;
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.gnt       = bus.busy ? w_onehot : '0;
    assign bus.op_sel    = r_op_sel;
    assign bus.mm_start  = (r_state == S_LAUNCH);
    assign bus.mm_clr    = (r_state == S_RESP) && r_err;
    assign bus.res_load  = (r_state == S_RESP) && !r_err;
    assign bus.rsp_err   = (r_state == S_RESP) && r_err;
    assign bus.rsp_valid = (r_state == S_RESP) ? w_onehot : '0;

`ifdef MATMUL_SCHED_STATS_EN
    logic [15:0] r_job_cnt;
    logic [7:0]  r_tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_job_cnt <= '0;
            r_tmo_cnt <= '0;
        end else if (r_state == S_RESP) begin
            if (r_err) begin
                if (r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end else begin
                if (r_job_cnt != '1) r_job_cnt <= r_job_cnt + 16'd1;
            end
        end
    end

    assign bus.job_cnt = r_job_cnt;
    assign bus.tmo_cnt = r_tmo_cnt;
`else
    assign bus.job_cnt = '0;
    assign bus.tmo_cnt = '0;
`endif
endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Scoreboard bench for matmul_job_scheduler with a behavioural 4x4 multiplier model.
module tb_matmul_job_scheduler;
    localparam int unsigned NR  = 4;
    localparam int unsigned IW  = 2;
    localparam int unsigned TMO = 16;

    typedef struct {
        int unsigned id;
        logic        err;
        int unsigned lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_job_scheduler_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

    matmul_job_scheduler #(
        .NUM_REQ(NR),
        .ID_W(IW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t         sb_q[$];
    int unsigned  n_chk = 0, n_fail = 0, n_rsp = 0, n_start = 0;
    int unsigned  cyc = 0, start_cyc = 0, rsp_cyc = 0, b2b_base = 0;
    int unsigned  exp_job = 0, exp_tmo = 0, mm_delay = 1;
    bit           chk_b2b = 1'b0;
    logic         mdl_done = 1'b0, inj_done = 1'b0;
    logic [255:0] mm_c = '0;

    assign bus.mm_done = mdl_done | inj_done;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester id's B matrix is id*16 + 1..16; with A = I the product is B itself.
    function automatic logic [255:0] exp_c(input int unsigned id);
        logic [255:0] v;
        v = '0;
        for (int unsigned k = 0; k < 16; k++) v[k*16 +: 16] = 16'(id*16 + k + 1);
        return v;
    endfunction

    function automatic logic [255:0] mm_compute(input int unsigned sel);
        logic [255:0] v;
        int unsigned  acc;
        v = '0;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++) begin
                acc = 0;
                for (int unsigned j = 0; j < 4; j++)
                    acc += ((r == j) ? 1 : 0) * (sel*16 + j*4 + c + 1);
                v[(r*4 + c)*16 +: 16] = 16'(acc);
            end
        return v;
    endfunction

    function automatic logic [23:0] stat_exp();
`ifdef MATMUL_SCHED_STATS_EN
        return {16'(exp_job), 8'(exp_tmo)};
`else
        return '0;
`endif
    endfunction

    // Multiplier model: operands latched at start, done pulsed mm_delay cycles later (0 = hang).
    initial begin : mm_model
        int unsigned cnt;
        bit          active;
        cnt    = 0;
        active = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mdl_done = 1'b0;
            if (!rst) begin
                active = 1'b0;
                cnt    = 0;
            end else begin
                if (bus.mm_clr) active = 1'b0;
                if (bus.mm_start) begin
                    mm_c   = mm_compute(32'(bus.op_sel));
                    cnt    = mm_delay;
                    active = (mm_delay != 0);
                end else if (active) begin
                    cnt--;
                    if (cnt == 0) begin
                        mdl_done = 1'b1;
                        active   = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc++;
                check("gnt_onehot", 1'($onehot(bus.gnt)), bus.busy);
                if (bus.busy) check("gnt_sel", bus.gnt, NR'(1) << bus.op_sel);
                if (bus.mm_start) begin
                    n_start++;
                    check("start_clr_excl", bus.mm_clr, 1'b0);
                    if (chk_b2b && n_rsp > b2b_base) check("b2b_gap", cyc - rsp_cyc, 2);
                    start_cyc = cyc;
                end
                if (bus.rsp_valid != '0) begin
                    if (sb_q.size() == 0) begin
                        check("rsp_unexpected", bus.rsp_valid, '0);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_valid", bus.rsp_valid, NR'(1) << e.id);
                        check("rsp_err", bus.rsp_err, e.err);
                        check("rsp_latency", cyc - start_cyc, e.lat);
                        check("res_load", bus.res_load, !e.err);
                        check("mm_clr", bus.mm_clr, e.err);
                        if (!e.err) check("c_result", mm_c, exp_c(e.id));
                    end
                    n_rsp++;
                    rsp_cyc = cyc;
                end else begin
                    check("no_strobe", {bus.res_load, bus.mm_clr, bus.rsp_err}, 3'b0);
                end
            end
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int unsigned id, input logic err, input int unsigned lat);
        exp_t e;
        e.id  = id;
        e.err = err;
        e.lat = lat;
        sb_q.push_back(e);
        if (err) exp_tmo++;
        else exp_job++;
    endtask

    task automatic check_zero(input string tag);
        check(tag, {bus.gnt, bus.op_sel, bus.mm_start, bus.mm_clr, bus.res_load, bus.rsp_valid,
                    bus.rsp_err, bus.busy, bus.job_cnt, bus.tmo_cnt}, '0);
    endtask

    task automatic check_stats(input string tag);
        check(tag, {bus.job_cnt, bus.tmo_cnt}, stat_exp());
    endtask

    // Waits for n more responses; each requester drops req once its response is seen.
    task automatic wait_rsp(input int unsigned n, input int unsigned budget);
        int unsigned target;
        target = n_rsp + n;
        for (int unsigned i = 0; i < budget; i++) begin
            tick();
            bus.req = bus.req & ~bus.rsp_valid;
            if (n_rsp >= target) break;
        end
        check("rsp_count", n_rsp, target);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        bus.req = '0;
        #1;
        check_zero("reset_async");
        repeat (2) tick();
        check_zero("reset_hold");
        exp_job = 0;
        exp_tmo = 0;
        rst     = 1'b1;
        tick();
    endtask

    initial begin : main
        int unsigned target, s0;
        bus.req = '0;
        #1 rst = 1'b0;
        repeat (3) tick();
        check_zero("reset_state");
        rst = 1'b1;
        tick();

        // Single job from requester 0, done 8 cycles after start.
        mm_delay = 8;
        push(0, 1'b0, 9);
        bus.req = 4'b0001;
        tick();
        check("t1_gnt", bus.gnt, 4'b0001);
        check("t1_opsel", bus.op_sel, 0);
        tick();
        check("t1_start", bus.mm_start, 1'b1);
        wait_rsp(1, 30);
        check("t1_starts", n_start, 1);
        tick();
        check("t1_idle", bus.busy, 1'b0);
        check_stats("t1_stats");

        // All four requesting from reset: 0,1,2,3,0 back-to-back.
        do_reset();
        mm_delay = 1;
        push(0, 1'b0, 2); push(1, 1'b0, 2); push(2, 1'b0, 2); push(3, 1'b0, 2); push(0, 1'b0, 2);
        b2b_base = n_rsp;
        target   = n_rsp + 5;
        chk_b2b  = 1'b1;
        bus.req  = 4'b1111;
        tick();
        for (int unsigned i = 0; i < 100; i++) begin
            check("t2_busy", bus.busy, 1'b1);
            if (n_rsp >= target) begin
                bus.req = '0;
                break;
            end
            tick();
        end
        chk_b2b = 1'b0;
        check("t2_count", n_rsp, target);
        tick();
        check("t2_idle", bus.busy, 1'b0);

        // Requester 2 then 1 joins: 1 next; then last=3 with 0 and 2 pending: 0 first.
        mm_delay = 6;
        push(2, 1'b0, 7);
        bus.req = 4'b0100;
        repeat (3) tick();
        push(1, 1'b0, 7);
        bus.req = bus.req | 4'b0010;
        wait_rsp(2, 60);
        tick();
        push(3, 1'b0, 7);
        bus.req = 4'b1000;
        wait_rsp(1, 40);
        tick();
        push(0, 1'b0, 7);
        push(2, 1'b0, 7);
        bus.req = 4'b0101;
        wait_rsp(2, 60);
        tick();

        // Hung multiplier.
        mm_delay = 0;
        push(0, 1'b1, TMO + 1);
        bus.req = 4'b0001;
        wait_rsp(1, 60);
        tick();
        check_stats("t4_stats");

        // Done on the timeout cycle wins; a done pulse in IDLE is ignored.
        mm_delay = TMO;
        push(1, 1'b0, TMO + 1);
        bus.req = 4'b0010;
        wait_rsp(1, 60);
        repeat (2) tick();
        s0 = n_start;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        check("t5_idle_done", bus.busy, 1'b0);
        tick();
        check("t5_idle_done2", bus.busy, 1'b0);
        check("t5_no_start", n_start, s0);
        check_stats("t5_stats");

        // Reset mid-WAIT abandons the job; requester 1 is served first afterwards.
        mm_delay = 0;
        bus.req  = 4'b0100;
        repeat (5) tick();
        check("t6_in_wait", bus.busy, 1'b1);
        rst = 1'b0;
        #1;
        check_zero("t6_async_reset");
        exp_job = 0;
        exp_tmo = 0;
        bus.req = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        mm_delay = 3;
        push(1, 1'b0, 4);
        bus.req = 4'b0010;
        tick();
        check("t6_gnt", bus.gnt, 4'b0010);
        wait_rsp(1, 30);
        tick();
        check_stats("t6_stats");
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
